// File: rtl/bbox_sample_iterator.sv
// Walks the sample grid of an accepted triangle's bounding box in raster order
// (x fastest), emitting one sample per clock while the triangle/color stay latched.
module bbox_sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H
);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_TEST = 1'b1
  } state_t;

  localparam logic signed [SIGFIG-1:0] ONE = {{(SIGFIG-1){1'b0}}, 1'b1};

  // Finer sample rates shrink the step; unknown encodings fall back to one sample per pixel.
  function automatic logic signed [SIGFIG-1:0] step_of(input logic [3:0] sel);
    logic signed [SIGFIG-1:0] s;
    case (sel)
      4'b1000: s = ONE << RADIX;
      4'b0100: s = ONE << (RADIX - 1);
      4'b0010: s = ONE << (RADIX - 2);
      4'b0001: s = ONE << (RADIX - 3);
      default: s = ONE << RADIX;
    endcase
    return s;
  endfunction

  state_t                   r_state;
  state_t                   w_next_state;

  logic signed [SIGFIG-1:0] r_tri [VERTS][AXIS];
  logic        [SIGFIG-1:0] r_color [COLORS];
  logic signed [SIGFIG-1:0] r_llx;
  logic signed [SIGFIG-1:0] r_urx;
  logic signed [SIGFIG-1:0] r_ury;
  logic signed [SIGFIG-1:0] r_step;
  logic signed [SIGFIG-1:0] r_sample [2];
  logic                     r_valid;

  logic signed [SIGFIG-1:0] w_sample_nxt [2];
  logic                     w_valid_nxt;
  logic                     w_accept;
  logic                     w_row_done;
  logic                     w_scan_done;

  assign w_accept    = (r_state == ST_WAIT) && validTri_R13H;
  // >= rather than == so a corner off the step grid still ends the row/scan.
  assign w_row_done  = (r_sample[0] >= r_urx);
  assign w_scan_done = w_row_done && (r_sample[1] >= r_ury);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT: begin
        if (w_accept) begin
          w_next_state = ST_TEST;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_TEST: begin
        if (w_scan_done) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_TEST;
        end
      end
      default: w_next_state = ST_WAIT;
    endcase
  end

  // State-decoded output
  always_comb begin
    halt_RnnnnL = 1'b0;
    case (r_state)
      ST_WAIT: halt_RnnnnL = 1'b1;
      ST_TEST: halt_RnnnnL = 1'b0;
      default: halt_RnnnnL = 1'b1;
    endcase
  end

  // Next sample position and valid flag
  always_comb begin
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_accept) begin
          w_sample_nxt = box_R13S[0];
          w_valid_nxt  = 1'b1;
        end else begin
          w_sample_nxt = r_sample;
          w_valid_nxt  = 1'b0;
        end
      end
      ST_TEST: begin
        if (w_scan_done) begin
          w_sample_nxt = r_sample;
          w_valid_nxt  = 1'b0;
        end else if (w_row_done) begin
          w_sample_nxt[0] = r_llx;
          w_sample_nxt[1] = r_sample[1] + r_step;
          w_valid_nxt     = 1'b1;
        end else begin
          w_sample_nxt[0] = r_sample[0] + r_step;
          w_sample_nxt[1] = r_sample[1];
          w_valid_nxt     = 1'b1;
        end
      end
      default: begin
        w_sample_nxt = r_sample;
        w_valid_nxt  = 1'b0;
      end
    endcase
  end

  // Triangle, color, box extents and step captured on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tri   <= '{default: '0};
      r_color <= '{default: '0};
      r_llx   <= '0;
      r_urx   <= '0;
      r_ury   <= '0;
      r_step  <= '0;
    end else if (w_accept) begin
      r_tri   <= tri_R13S;
      r_color <= color_R13U;
      r_llx   <= box_R13S[0][0];
      r_urx   <= box_R13S[1][0];
      r_ury   <= box_R13S[1][1];
      r_step  <= step_of(subSample_RnnnnU);
    end
  end

  // Sample position and valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= '{default: '0};
      r_valid  <= 1'b0;
    end else begin
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign tri_R14S       = r_tri;
  assign color_R14U     = r_color;
  assign sample_R14S    = r_sample;
  assign validSamp_R14H = r_valid;

endmodule

// File: tb/tb_bbox_sample_iterator.sv
// Self-checking bench: a queue-based raster model predicts every cycle, and
// directed jobs pin the emitted sample sequences to hand-computed literals.
module tb_bbox_sample_iterator;
  localparam int SF = 24;

  logic                 clk;
  logic                 rst;
  logic signed [SF-1:0] tri_in [3][3];
  logic        [SF-1:0] col_in [3];
  logic signed [SF-1:0] box_in [2][2];
  logic                 valid_tri;
  logic        [3:0]    sub_sample;
  logic                 halt;
  logic signed [SF-1:0] tri_out [3][3];
  logic        [SF-1:0] col_out [3];
  logic signed [SF-1:0] samp_out [2];
  logic                 valid_samp;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_started = 1'b0;
  bit m_busy    = 1'b0;
  int m_sx = 0, m_sy = 0;
  int m_qx[$], m_qy[$];
  int m_tri [3][3];
  int m_col [3];

  // samples emitted by the DUT during the current job
  int lx[$], ly[$];

  bbox_sample_iterator dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_in),
    .color_R13U       (col_in),
    .box_R13S         (box_in),
    .validTri_R13H    (valid_tri),
    .subSample_RnnnnU (sub_sample),
    .halt_RnnnnL      (halt),
    .tri_R14S         (tri_out),
    .color_R14U       (col_out),
    .sample_R14S      (samp_out),
    .validSamp_R14H   (valid_samp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int step_of(input logic [3:0] sel);
    case (sel)
      4'b1000: return 1024;
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  function automatic void build(input int llx, input int lly, input int urx, input int ury, input int st);
    int x, y;
    m_qx.delete();
    m_qy.delete();
    y = lly;
    while (1) begin
      x = llx;
      while (1) begin
        m_qx.push_back(x);
        m_qy.push_back(y);
        if (x >= urx) break;
        x += st;
      end
      if (y >= ury) break;
      y += st;
    end
  endfunction

  // Model: list every sample of the box at accept, then emit one per edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_started = 1'b1;
        m_busy = 1'b0;
        m_sx = 0;
        m_sy = 0;
        m_qx.delete();
        m_qy.delete();
        for (int v = 0; v < 3; v++) for (int a = 0; a < 3; a++) m_tri[v][a] = 0;
        for (int c = 0; c < 3; c++) m_col[c] = 0;
      end else if (m_started) begin
        if (!m_busy) begin
          if (valid_tri) begin
            build(int'(box_in[0][0]), int'(box_in[0][1]), int'(box_in[1][0]), int'(box_in[1][1]), step_of(sub_sample));
            for (int v = 0; v < 3; v++) for (int a = 0; a < 3; a++) m_tri[v][a] = int'(tri_in[v][a]);
            for (int c = 0; c < 3; c++) m_col[c] = int'(col_in[c]);
            m_busy = 1'b1;
            m_sx = m_qx[0];
            m_sy = m_qy[0];
          end
        end else begin
          void'(m_qx.pop_front());
          void'(m_qy.pop_front());
          if (m_qx.size() == 0) begin
            m_busy = 1'b0;
          end else begin
            m_sx = m_qx[0];
            m_sy = m_qy[0];
          end
        end
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("valid", int'(valid_samp), int'(m_busy));
        chk("halt", int'(halt), int'(!m_busy));
        chk("sample_x", int'(samp_out[0]), m_sx);
        chk("sample_y", int'(samp_out[1]), m_sy);
        for (int v = 0; v < 3; v++) for (int a = 0; a < 3; a++) chk("tri", int'(tri_out[v][a]), m_tri[v][a]);
        for (int c = 0; c < 3; c++) chk("color", int'(col_out[c]), m_col[c]);
        if (valid_samp === 1'b1) begin
          lx.push_back(int'(samp_out[0]));
          ly.push_back(int'(samp_out[1]));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic set_job(input int llx, input int lly, input int urx, input int ury, input logic [3:0] ss, input int seed);
    box_in[0][0] = SF'(llx);
    box_in[0][1] = SF'(lly);
    box_in[1][0] = SF'(urx);
    box_in[1][1] = SF'(ury);
    sub_sample = ss;
    for (int v = 0; v < 3; v++) for (int a = 0; a < 3; a++) tri_in[v][a] = SF'(seed + v * 10 + a);
    for (int c = 0; c < 3; c++) col_in[c] = SF'(seed * 3 + c);
  endtask

  // Called at posedge+1 with the DUT idle; leaves valid_tri low after the accept edge.
  task automatic run_job(input int llx, input int lly, input int urx, input int ury, input logic [3:0] ss, input int seed);
    set_job(llx, lly, urx, ury, ss, seed);
    lx.delete();
    ly.delete();
    valid_tri = 1'b1;
    @(posedge clk);
    #1;
    valid_tri = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!m_busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({nm, "_timeout"}, int'(done), 1);
    @(negedge clk);
  endtask

  task automatic expect_at(input string nm, input int idx, input int ex, input int ey);
    chk({nm, "_x"}, (idx < lx.size()) ? lx[idx] : -99999, ex);
    chk({nm, "_y"}, (idx < ly.size()) ? ly[idx] : -99999, ey);
  endtask

  initial begin
    int xs6[6] = '{0, 1024, 2048, 0, 1024, 2048};
    int ys6[6] = '{0, 0, 0, 1024, 1024, 1024};
    int idle;
    bit got;

    // reset with a triangle offered: it must not be taken
    rst = 1'b1;
    set_job(0, 0, 2048, 1024, 4'b1000, 7);
    valid_tri = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid_samp), 0);
    chk("rst_halt", int'(halt), 1);
    chk("rst_sx", int'(samp_out[0]), 0);
    chk("rst_sy", int'(samp_out[1]), 0);
    rst = 1'b0;
    valid_tri = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", int'(valid_samp), 0);

    // 1x, 2048x1024 box: six samples
    run_job(0, 0, 2048, 1024, 4'b1000, 100);
    wait_idle("b1x");
    chk("b1x_count", lx.size(), 6);
    for (int i = 0; i < 6; i++) expect_at("b1x", i, xs6[i], ys6[i]);
    chk("b1x_end_halt", int'(halt), 1);

    // degenerate box
    run_job(5120, 3072, 5120, 3072, 4'b1000, 200);
    wait_idle("degen");
    chk("degen_count", lx.size(), 1);
    expect_at("degen", 0, 5120, 3072);

    // 4x
    run_job(0, 0, 512, 512, 4'b0100, 300);
    wait_idle("b4x");
    chk("b4x_count", lx.size(), 4);
    expect_at("b4x0", 0, 0, 0);
    expect_at("b4x1", 1, 512, 0);
    expect_at("b4x2", 2, 0, 512);
    expect_at("b4x3", 3, 512, 512);

    // reset after third sample, then a fresh job starts at its own LL
    run_job(0, 0, 2048, 1024, 4'b1000, 400);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (lx.size() >= 3) begin
        got = 1'b1;
        break;
      end
    end
    chk("abort_reach3", int'(got), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_valid", int'(valid_samp), 0);
    chk("abort_halt", int'(halt), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_count", lx.size(), 3);
    run_job(1024, 2048, 1536, 2560, 4'b0100, 500);
    wait_idle("restart");
    chk("restart_count", lx.size(), 4);
    expect_at("restart0", 0, 1024, 2048);
    expect_at("restart3", 3, 1536, 2560);

    // valid held with a different box during the scan
    set_job(0, 0, 2048, 1024, 4'b1000, 600);
    lx.delete();
    ly.delete();
    valid_tri = 1'b1;
    @(posedge clk);
    #1;
    set_job(3072, 1024, 4096, 1024, 4'b1000, 700);
    idle = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!m_busy) idle++;
      else if (idle > 0) begin
        got = 1'b1;
        break;
      end
    end
    valid_tri = 1'b0;
    chk("hold_second_accept", int'(got), 1);
    chk("hold_bubble", idle, 1);
    wait_idle("hold");
    chk("hold_count", lx.size(), 8);
    for (int i = 0; i < 6; i++) expect_at("hold", i, xs6[i], ys6[i]);
    expect_at("hold2_0", 6, 3072, 1024);
    expect_at("hold2_1", 7, 4096, 1024);

    // remaining rates, illegal encoding, misaligned and negative boxes
    run_job(0, 0, 256, 256, 4'b0010, 800);
    wait_idle("b16x");
    chk("b16x_count", lx.size(), 4);
    expect_at("b16x1", 1, 256, 0);
    run_job(128, 0, 384, 128, 4'b0001, 900);
    wait_idle("b64x");
    chk("b64x_count", lx.size(), 6);
    expect_at("b64x5", 5, 384, 128);
    run_job(0, 0, 1024, 0, 4'b0110, 1000);
    wait_idle("illegal");
    chk("illegal_count", lx.size(), 2);
    expect_at("illegal1", 1, 1024, 0);
    run_job(0, 0, 1500, 1000, 4'b1000, 1100);
    wait_idle("misal");
    chk("misal_count", lx.size(), 6);
    expect_at("misal5", 5, 2048, 1024);
    run_job(-1024, -1024, 0, 0, 4'b1000, 1200);
    wait_idle("neg");
    chk("neg_count", lx.size(), 4);
    expect_at("neg0", 0, -1024, -1024);
    expect_at("neg3", 3, 0, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
